// File: rtl/stereo_frame_buffer.sv
// stereo_frame_buffer
//   Dual-image (left/right) pixel store feeding the disparity engine.
//   Captures one left and one right frame from the camera write stream,
//   then holds both frames stable while the engine works on them.
//
// Ports
//   clk           system clock, rising edge
//   reset         asynchronous, active-low reset
//   wr_valid      write-stream pixel valid
//   wr_sel        write target: 1 = left, 0 = right
//   wr_sof        start of frame for wr_sel; rewinds that frame's pointer
//   wr_data       pixel value, raster order
//   idle          disparity engine idle flag
//   buffer_href   read column
//   buffer_vref   read row
//   image_sel     read select: 1 = left, 0 = right
//   image_data    registered read data (latency 1)
//   buffer_ready  both frames complete and held
//   overflow      sticky: a pixel was dropped while filling
//   frame_cnt     completed frame pairs, wraps 255 -> 0
module stereo_frame_buffer #(
    parameter int unsigned WIDTH  = 20,
    parameter int unsigned HEIGHT = 7,
    parameter int unsigned PIX_W  = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_valid,
    input  logic             wr_sel,
    input  logic             wr_sof,
    input  logic [PIX_W-1:0] wr_data,
    input  logic             idle,
    input  logic [9:0]       buffer_href,
    input  logic [9:0]       buffer_vref,
    input  logic             image_sel,
    output logic [PIX_W-1:0] image_data,
    output logic             buffer_ready,
    output logic             overflow,
    output logic [7:0]       frame_cnt
);

    localparam int unsigned DEPTH = WIDTH * HEIGHT;
    localparam int unsigned AW    = $clog2(DEPTH);
    localparam int unsigned LAST  = DEPTH - 1;

    typedef enum logic [1:0] {
        S_FILL   = 2'd0,
        S_READY  = 2'd1,
        S_LOCKED = 2'd2
    } state_t;

    // Frame storage: index 1 = left, 0 = right (matches wr_sel/image_sel).
    logic [PIX_W-1:0] mem [2][DEPTH];

    state_t              state_q,      state_d;
    logic [1:0][AW-1:0]  ptr_q,        ptr_d;
    logic [1:0]          full_q,       full_d;
    logic                overflow_q,   overflow_d;
    logic [7:0]          frame_cnt_q,  frame_cnt_d;
    logic                ready_q,      ready_d;
    logic [PIX_W-1:0]    image_data_q, image_data_d;

    logic                mem_we;
    logic [AW-1:0]       mem_waddr;

    logic [31:0]         rd_lin;
    logic [AW-1:0]       rd_addr;
    logic                rd_in_range;

    // Read path: runs every cycle in every state; out-of-range coordinates read 0.
    always_comb begin
        rd_lin       = WIDTH * 32'(buffer_vref) + 32'(buffer_href);
        rd_addr      = rd_lin[AW-1:0];
        rd_in_range  = (32'(buffer_href) < WIDTH) && (32'(buffer_vref) < HEIGHT);
        image_data_d = rd_in_range ? mem[image_sel][rd_addr] : '0;
    end

    // Next-state / write-control logic.
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        full_d      = full_q;
        overflow_d  = overflow_q;
        frame_cnt_d = frame_cnt_q;
        mem_we      = 1'b0;
        mem_waddr   = '0;

        unique case (state_q)
            S_FILL: begin
                if (wr_sof) begin
                    // SOF rewinds the selected frame and reopens it for writing.
                    full_d[wr_sel] = 1'b0;
                    if (wr_valid) begin
                        mem_we         = 1'b1;
                        mem_waddr      = '0;
                        ptr_d[wr_sel]  = AW'(1);
                    end else begin
                        ptr_d[wr_sel]  = '0;
                    end
                end else if (wr_valid) begin
                    if (full_q[wr_sel]) begin
                        overflow_d = 1'b1;
                    end else begin
                        mem_we    = 1'b1;
                        mem_waddr = ptr_q[wr_sel];
                        // Pointer parks on the last address once the frame is full.
                        if (ptr_q[wr_sel] == AW'(LAST)) begin
                            full_d[wr_sel] = 1'b1;
                        end else begin
                            ptr_d[wr_sel]  = ptr_q[wr_sel] + AW'(1);
                        end
                    end
                end
                if (&full_q) begin
                    state_d     = S_READY;
                    frame_cnt_d = frame_cnt_q + 8'd1;
                end
            end
            S_READY: begin
                if (!idle) begin
                    state_d = S_LOCKED;
                end
            end
            S_LOCKED: begin
                if (idle) begin
                    // Re-arm for the next pair on the same edge that leaves LOCKED.
                    state_d    = S_FILL;
                    ptr_d      = '0;
                    full_d     = '0;
                    overflow_d = 1'b0;
                end
            end
            default: begin
                state_d = S_FILL;
            end
        endcase

        ready_d = (state_d == S_READY) || (state_d == S_LOCKED);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= S_FILL;
            ptr_q        <= '0;
            full_q       <= '0;
            overflow_q   <= 1'b0;
            frame_cnt_q  <= '0;
            ready_q      <= 1'b0;
            image_data_q <= '0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            full_q       <= full_d;
            overflow_q   <= overflow_d;
            frame_cnt_q  <= frame_cnt_d;
            ready_q      <= ready_d;
            image_data_q <= image_data_d;
        end
    end

    // Pixel RAM: no reset; a same-address read in this cycle sees the old value.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[wr_sel][mem_waddr] <= wr_data;
        end
    end

    assign image_data   = image_data_q;
    assign buffer_ready = ready_q;
    assign overflow     = overflow_q;
    assign frame_cnt    = frame_cnt_q;

endmodule

// File: tb/tb_stereo_frame_buffer.sv
// tb_stereo_frame_buffer
//   Directed self-checking bench for stereo_frame_buffer.
module tb_stereo_frame_buffer;

    logic       clk;
    logic       reset;
    logic       wr_valid;
    logic       wr_sel;
    logic       wr_sof;
    logic [7:0] wr_data;
    logic       idle;
    logic [9:0] buffer_href;
    logic [9:0] buffer_vref;
    logic       image_sel;
    logic [7:0] image_data;
    logic       buffer_ready;
    logic       overflow;
    logic [7:0] frame_cnt;

    int n_total;
    int n_pass;
    int n_fail;

    stereo_frame_buffer #(
        .WIDTH  (20),
        .HEIGHT (7),
        .PIX_W  (8)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .wr_valid     (wr_valid),
        .wr_sel       (wr_sel),
        .wr_sof       (wr_sof),
        .wr_data      (wr_data),
        .idle         (idle),
        .buffer_href  (buffer_href),
        .buffer_vref  (buffer_vref),
        .image_sel    (image_sel),
        .image_data   (image_data),
        .buffer_ready (buffer_ready),
        .overflow     (overflow),
        .frame_cnt    (frame_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input int obs, input int exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic write_px(input logic sel, input logic sof, input logic [7:0] data);
        wr_sel   = sel;
        wr_sof   = sof;
        wr_data  = data;
        wr_valid = 1'b1;
        tick();
        wr_valid = 1'b0;
        wr_sof   = 1'b0;
    endtask

    task automatic rd(input string tag, input int href, input int vref,
                      input logic sel, input int exp);
        buffer_href = 10'(href);
        buffer_vref = 10'(vref);
        image_sel   = sel;
        tick();
        check(tag, int'(image_data), exp);
    endtask

    initial begin
        n_total     = 0;
        n_pass      = 0;
        n_fail      = 0;
        reset       = 1'b0;
        wr_valid    = 1'b0;
        wr_sel      = 1'b0;
        wr_sof      = 1'b0;
        wr_data     = '0;
        idle        = 1'b1;
        buffer_href = '0;
        buffer_vref = '0;
        image_sel   = 1'b0;

        // Reset state
        repeat (3) tick();
        check("rst_image_data", int'(image_data), 0);
        check("rst_ready", int'(buffer_ready), 0);
        check("rst_overflow", int'(overflow), 0);
        check("rst_frame_cnt", int'(frame_cnt), 0);
        reset = 1'b1;
        tick();

        // Fill: left value = addr, right value = addr + 100
        for (int i = 0; i < 140; i++) write_px(1'b1, i == 0, 8'(i));
        for (int i = 0; i < 140; i++) write_px(1'b0, i == 0, 8'(i + 100));
        check("ready_at_last_write", int'(buffer_ready), 0);
        check("cnt_at_last_write", int'(frame_cnt), 0);
        tick();
        check("ready_after_fill", int'(buffer_ready), 1);
        check("cnt_after_fill", int'(frame_cnt), 1);
        check("ovf_after_fill", int'(overflow), 0);

        // Reads
        rd("rd_left_3_2", 3, 2, 1'b1, 43);
        rd("rd_right_3_2", 3, 2, 1'b0, 143);
        rd("rd_href_20", 20, 2, 1'b1, 0);
        rd("rd_vref_7", 0, 7, 1'b0, 0);
        rd("rd_left_last", 19, 6, 1'b1, 139);
        rd("rd_right_last", 19, 6, 1'b0, 239);
        rd("rd_left_first", 0, 0, 1'b1, 0);

        // Lock: writes ignored while held
        idle = 1'b0;
        tick();
        check("ready_locked", int'(buffer_ready), 1);
        for (int i = 0; i < 140; i++) write_px(1'b1, 1'b0, 8'hFF);
        for (int i = 0; i < 140; i++) write_px(1'b0, 1'b0, 8'hFF);
        check("ovf_locked", int'(overflow), 0);
        check("ready_locked_after_wr", int'(buffer_ready), 1);
        rd("lock_left_3_2", 3, 2, 1'b1, 43);
        rd("lock_right_3_2", 3, 2, 1'b0, 143);
        rd("lock_left_last", 19, 6, 1'b1, 139);
        rd("lock_right_first", 0, 0, 1'b0, 100);
        idle = 1'b1;
        tick();
        check("ready_after_unlock", int'(buffer_ready), 0);
        check("cnt_after_unlock", int'(frame_cnt), 1);

        // Overflow: left value = i + 50, 141st pixel dropped
        for (int i = 0; i < 140; i++) write_px(1'b1, 1'b0, 8'(i + 50));
        check("ovf_before_141", int'(overflow), 0);
        write_px(1'b1, 1'b0, 8'd190);
        check("ovf_after_141", int'(overflow), 1);
        check("ready_left_only", int'(buffer_ready), 0);
        rd("ovf_left_139", 19, 6, 1'b1, 189);
        rd("ovf_left_1", 1, 0, 1'b1, 51);
        rd("ovf_right_untouched", 3, 2, 1'b0, 143);
        write_px(1'b1, 1'b1, 8'd9);
        rd("sof_left_0", 0, 0, 1'b1, 9);
        check("ovf_sticky", int'(overflow), 1);

        // Mid-fill asynchronous reset
        for (int i = 0; i < 70; i++) write_px(1'b1, 1'b0, 8'hAA);
        reset = 1'b0;
        #1;
        check("midrst_image_data", int'(image_data), 0);
        check("midrst_ready", int'(buffer_ready), 0);
        check("midrst_overflow", int'(overflow), 0);
        check("midrst_frame_cnt", int'(frame_cnt), 0);
        #2;
        reset = 1'b1;
        tick();

        // Fresh pair: left = addr + 1, right = addr + 2
        for (int i = 0; i < 140; i++) write_px(1'b1, 1'b0, 8'(i + 1));
        for (int i = 0; i < 139; i++) write_px(1'b0, 1'b0, 8'(i + 2));
        check("pair_ready_279", int'(buffer_ready), 0);
        write_px(1'b0, 1'b0, 8'd141);
        check("pair_ready_280", int'(buffer_ready), 0);
        tick();
        check("pair_ready_after", int'(buffer_ready), 1);
        check("pair_frame_cnt", int'(frame_cnt), 1);
        rd("pair_left_3_2", 3, 2, 1'b1, 44);
        rd("pair_right_3_2", 3, 2, 1'b0, 45);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
